// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses pll_reset, waits for a stable lock, then releases rst_out_n.
// Optional retry counter enabled by defining PLL_RST_SEQ_RETRY_CNT_EN.
module pll_rst_seq #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 500000,
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       rst_out_n,
  output logic [1:0] state_o,
  output logic [7:0] retry_cnt
);

  localparam int unsigned MAX_RS  = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (LOCK_TIMEOUT > MAX_RS) ? LOCK_TIMEOUT : MAX_RS;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC);

  typedef enum logic [1:0] {
    PWRUP     = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic             rst_meta;
  logic             rst_sync;
  logic             lock_meta;
  logic             lock_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pll_reset_d;
  logic             rst_out_n_d;
  logic [1:0]       state_o_d;

  // Reset release synchronizer; assertion stays asynchronous
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  // Lock synchronizer; the FSM only ever looks at lock_s
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // State register, cycle counter and registered outputs share one edge
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= PWRUP;
      cnt       <= '0;
      pll_reset <= 1'b1;
      rst_out_n <= 1'b0;
      state_o   <= 2'd0;
    end else if (rst_sync) begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pll_reset <= pll_reset_d;
      rst_out_n <= rst_out_n_d;
      state_o   <= state_o_d;
    end
  end

  // Next-state logic; lock loss is checked before the counter terminal value
  always_comb begin
    state_nxt = state;
    unique case (state)
      PWRUP: begin
        if (cnt == CNT_W'(RST_CYCLES - 1)) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s)                                 state_nxt = STABLE;
        else if (cnt == CNT_W'(LOCK_TIMEOUT - 1))   state_nxt = PWRUP;
      end
      STABLE: begin
        if (!lock_s)                                state_nxt = WAIT_LOCK;
        else if (cnt == CNT_W'(STABLE_CYCLES - 1))  state_nxt = RUN;
      end
      RUN: begin
        if (!lock_s) state_nxt = PWRUP;
      end
      default: state_nxt = PWRUP;
    endcase
    cnt_nxt = (state_nxt != state) ? '0 : CNT_W'(cnt + 1'b1);
  end

  // Output next values decoded from the next state so they register with it
  always_comb begin
    pll_reset_d = 1'b0;
    rst_out_n_d = 1'b0;
    state_o_d   = state_nxt;
    if (state_nxt == PWRUP) pll_reset_d = 1'b1;
    if (state_nxt == RUN)   rst_out_n_d = 1'b1;
  end

`ifdef PLL_RST_SEQ_RETRY_CNT_EN
  logic       retry_inc;
  logic [7:0] retry_q;

  assign retry_inc = (state == WAIT_LOCK) && (state_nxt == PWRUP);

  // Saturating count of lock timeouts
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      retry_q <= 8'd0;
    end else if (rst_sync && retry_inc && (retry_q != 8'hFF)) begin
      retry_q <= retry_q + 8'd1;
    end
  end

  assign retry_cnt = retry_q;
`else
  assign retry_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq with RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8.
module tb_pll_rst_seq;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       pll_lock;
  logic       pll_reset;
  logic       rst_out_n;
  logic [1:0] state_o;
  logic [7:0] retry_cnt;

  int checks;
  int errors;

`ifdef PLL_RST_SEQ_RETRY_CNT_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam logic [7:0] R1 = RETRY_EN ? 8'd1 : 8'd0;

  typedef struct {
    logic        rst_n;
    logic        lock;
    int unsigned n;
    logic [1:0]  st;
    logic        pr;
    logic        ro;
    logic [7:0]  rc;
    string       name;
  } vec_t;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       pr;
    logic       ro;
    logic [7:0] rc;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[18];

  pll_rst_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (100),
    .STABLE_CYCLES(8)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .pll_lock (pll_lock),
    .pll_reset(pll_reset),
    .rst_out_n(rst_out_n),
    .state_o  (state_o),
    .retry_cnt(retry_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time (CHECKS %0d ERRORS %0d)", checks, errors + 1);
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic rst_n, input logic lock, input int unsigned n,
                              input logic [1:0] st, input logic pr, input logic ro,
                              input logic [7:0] rc, input string name);
    vec_t v;
    v.rst_n = rst_n; v.lock = lock; v.n = n;
    v.st = st; v.pr = pr; v.ro = ro; v.rc = rc; v.name = name;
    return v;
  endfunction

  task automatic push_exp(input string name, input logic [1:0] st, input logic pr,
                          input logic ro, input logic [7:0] rc);
    exp_t e;
    e.name = name; e.st = st; e.pr = pr; e.ro = ro; e.rc = rc;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expected entry queued");
    end else begin
      e = exp_q.pop_front();
      if (state_o !== e.st || pll_reset !== e.pr || rst_out_n !== e.ro || retry_cnt !== e.rc) begin
        errors++;
        $display("FAIL %s: got state=%0d pll_reset=%0b rst_out_n=%0b retry=%0d, want state=%0d pll_reset=%0b rst_out_n=%0b retry=%0d",
                 e.name, state_o, pll_reset, rst_out_n, retry_cnt, e.st, e.pr, e.ro, e.rc);
      end
    end
  endtask

  // Drive inputs at a falling edge, run v.n rising edges, then compare
  task automatic apply(input vec_t v);
    @(negedge sys_clk);
    sys_rst_n = v.rst_n;
    pll_lock  = v.lock;
    push_exp(v.name, v.st, v.pr, v.ro, v.rc);
    repeat (v.n) @(posedge sys_clk);
    #1;
    check_out();
  endtask

  initial begin
    logic [7:0] rc_exp;
    checks    = 0;
    errors    = 0;
    sys_rst_n = 1'b0;
    pll_lock  = 1'b0;

    // Power-up, normal lock (rst_out_n on the 11th edge counting the sampling edge),
    // lock loss in RUN, first timeout
    tbl[0]  = mk(1, 0, 5,  0, 1, 0, 0,  "pwrup_hold");
    tbl[1]  = mk(1, 0, 1,  1, 0, 0, 0,  "pwrup_exit");
    tbl[2]  = mk(1, 0, 10, 1, 0, 0, 0,  "wait_10");
    tbl[3]  = mk(1, 1, 2,  1, 0, 0, 0,  "lock_sync");
    tbl[4]  = mk(1, 1, 1,  2, 0, 0, 0,  "enter_stable");
    tbl[5]  = mk(1, 1, 7,  2, 0, 0, 0,  "stable_hold");
    tbl[6]  = mk(1, 1, 1,  3, 0, 1, 0,  "run_release");
    tbl[7]  = mk(1, 1, 20, 3, 0, 1, 0,  "run_hold");
    tbl[8]  = mk(1, 0, 2,  3, 0, 1, 0,  "loss_sync");
    tbl[9]  = mk(1, 0, 1,  0, 1, 0, 0,  "loss_pwrup");
    tbl[10] = mk(1, 0, 3,  0, 1, 0, 0,  "repwrup_hold");
    tbl[11] = mk(1, 0, 1,  1, 0, 0, 0,  "rewait");
    tbl[12] = mk(1, 0, 99, 1, 0, 0, 0,  "timeout_edge");
    tbl[13] = mk(1, 0, 1,  0, 1, 0, R1, "timeout_retry");
    tbl[14] = mk(1, 0, 3,  0, 1, 0, R1, "retry_pwrup");
    tbl[15] = mk(1, 0, 1,  1, 0, 0, R1, "retry_wait");
    tbl[16] = mk(1, 1, 3,  2, 0, 0, R1, "relock");
    tbl[17] = mk(1, 1, 5,  2, 0, 0, R1, "stable_5");

    repeat (3) @(posedge sys_clk);
    #1;
    push_exp("reset_values", 2'd0, 1'b1, 1'b0, 8'd0);
    check_out();

    foreach (tbl[i]) apply(tbl[i]);

    // One-cycle glitch in STABLE forces a fresh full STABLE period
    apply(mk(1, 0, 1, 2, 0, 0, R1, "glitch_lo"));
    apply(mk(1, 1, 1, 2, 0, 0, R1, "glitch_hi"));
    apply(mk(1, 1, 1, 1, 0, 0, R1, "glitch_wait"));
    apply(mk(1, 1, 1, 2, 0, 0, R1, "glitch_restable"));
    apply(mk(1, 1, 7, 2, 0, 0, R1, "full_stable"));
    apply(mk(1, 1, 1, 3, 0, 1, R1, "glitch_run"));

    // Lock seen on the timeout cycle wins over the retry
    apply(mk(1, 0, 3,  0, 1, 0, R1, "loss2_pwrup"));
    apply(mk(1, 0, 4,  1, 0, 0, R1, "loss2_wait"));
    apply(mk(1, 0, 97, 1, 0, 0, R1, "prio_pre"));
    apply(mk(1, 1, 2,  1, 0, 0, R1, "prio_sync"));
    apply(mk(1, 1, 1,  2, 0, 0, R1, "prio_stable"));

    // Asynchronous reset in STABLE, checked before any further clock edge
    @(negedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    push_exp("midop_reset", 2'd0, 1'b1, 1'b0, 8'd0);
    check_out();
    apply(mk(0, 0, 3, 0, 1, 0, 0, "reset_held"));

    // Repeated timeouts drive retry_cnt into saturation
    apply(mk(1, 0, 5, 0, 1, 0, 0, "sat_pwrup"));
    apply(mk(1, 0, 1, 1, 0, 0, 0, "sat_wait"));
    for (int i = 1; i <= 300; i++) begin
      rc_exp = RETRY_EN ? ((i > 255) ? 8'd255 : 8'(i)) : 8'd0;
      apply(mk(1, 0, 100, 0, 1, 0, rc_exp, "sat_timeout"));
      apply(mk(1, 0, 4,   1, 0, 0, rc_exp, "sat_rewait"));
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
